// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit CPU: boot-loads a word RAM from a byte
// stream while holding the CPU in reset, then serves registered reads and byte-strobed writes.
module cpu_mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int BOOT_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adr,
    input  logic [15:0] memOut,
    input  logic        memwrite_a,
    input  logic        memwrite_b,
    output logic [15:0] memdata,
    input  logic        boot_valid,
    input  logic [7:0]  boot_data,
    output logic        boot_ready,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        oob_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] BOOT_LEN_C = BOOT_LEN[ADDR_W:0];

    typedef enum logic [1:0] {
        BOOT_LO = 2'd0,
        BOOT_HI = 2'd1,
        RUN     = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W:0]     ptr_q;
    logic [7:0]          held_lo_q;
    logic [15:0]         memdata_q;
    logic                boot_ready_q;
    logic                cpu_hold_q;
    logic                boot_done_q;
    logic                oob_err_q;
    logic [15:0]         mem_q [DEPTH];

    logic                accept_d;
    logic                in_range_d;
    logic [ADDR_W:0]     ptr_inc_d;
    logic                wr_lo_d;
    logic                wr_hi_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [15:0]         wr_data_d;

    // Decode byte acceptance, address range and the single RAM write port.
    always_comb begin
        accept_d   = boot_valid && boot_ready_q && (state_q != RUN);
        in_range_d = (adr[15:ADDR_W] == {(16-ADDR_W){1'b0}});
        ptr_inc_d  = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
        wr_lo_d    = 1'b0;
        wr_hi_d    = 1'b0;
        wr_addr_d  = ptr_q[ADDR_W-1:0];
        wr_data_d  = {boot_data, held_lo_q};
        case (state_q)
            BOOT_HI: begin
                if (accept_d) begin
                    wr_lo_d = 1'b1;
                    wr_hi_d = 1'b1;
                end else begin
                    wr_lo_d = 1'b0;
                    wr_hi_d = 1'b0;
                end
            end
            RUN: begin
                wr_addr_d = adr[ADDR_W-1:0];
                wr_data_d = memOut;
                if (in_range_d) begin
                    wr_lo_d = memwrite_a;
                    wr_hi_d = memwrite_b;
                end else begin
                    wr_lo_d = 1'b0;
                    wr_hi_d = 1'b0;
                end
            end
            default: begin
                wr_lo_d = 1'b0;
                wr_hi_d = 1'b0;
            end
        endcase
    end

    // RAM byte lanes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_lo_d) begin
            mem_q[wr_addr_d][7:0] <= wr_data_d[7:0];
        end
        if (wr_hi_d) begin
            mem_q[wr_addr_d][15:8] <= wr_data_d[15:8];
        end
    end

    // Boot loader / service FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT_LO;
            ptr_q        <= '0;
            held_lo_q    <= 8'h00;
            memdata_q    <= 16'h0000;
            boot_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            boot_done_q  <= 1'b0;
            oob_err_q    <= 1'b0;
        end else begin
            case (state_q)
                BOOT_LO: begin
                    memdata_q    <= 16'h0000;
                    boot_ready_q <= 1'b1;
                    if (accept_d) begin
                        held_lo_q <= boot_data;
                        state_q   <= BOOT_HI;
                    end
                end
                BOOT_HI: begin
                    memdata_q    <= 16'h0000;
                    boot_ready_q <= 1'b1;
                    if (accept_d) begin
                        ptr_q <= ptr_inc_d;
                        if (ptr_inc_d == BOOT_LEN_C) begin
                            state_q      <= RUN;
                            boot_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            boot_done_q  <= 1'b1;
                        end else begin
                            state_q <= BOOT_LO;
                        end
                    end
                end
                RUN: begin
                    // Read-before-write falls out of sampling the old RAM word here.
                    if (in_range_d) begin
                        memdata_q <= mem_q[adr[ADDR_W-1:0]];
                    end else begin
                        memdata_q <= 16'h0000;
                        oob_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BOOT_LO;
                end
            endcase
        end
    end

    assign memdata    = memdata_q;
    assign boot_ready = boot_ready_q;
    assign cpu_hold   = cpu_hold_q;
    assign boot_done  = boot_done_q;
    assign oob_err    = oob_err_q;

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the 16-bit CPU's memory port: it services the CPU's address, write-data and byte-write strobes with a registered 16-bit read-data return, backed by an on-chip word RAM. After reset it first runs a boot-loader state machine that fills the RAM from an 8-bit byte stream while holding the CPU in reset, then releases the CPU and enters normal service. It sits inside the pad ring next to the CPU core, on the opposite end of the CPU memory interface.

## Interface

- ADDR_W, 8, RAM word-address width; depth = 2^ADDR_W words
- BOOT_LEN, 256, number of 16-bit words loaded at boot (1..2^ADDR_W)
- clk  in  1  single clock, all state rising-edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- adr  in  16  CPU word address
- memOut  in  16  CPU write data
- memwrite_a  in  1  write strobe, low byte memOut[7:0]
- memwrite_b  in  1  write strobe, high byte memOut[15:8]
- memdata  out  16  read data to CPU
- boot_valid  in  1  boot byte present
- boot_data  in  8  boot byte
- boot_ready  out  1  loader accepting bytes
- cpu_hold  out  1  active-high, holds CPU in reset
- boot_done  out  1  loader finished
- oob_err  out  1  sticky out-of-range access flag

## Operation

- States: BOOT_LO, BOOT_HI, RUN. Word pointer ptr (ADDR_W+1 bits).
- Reset asserted: state=BOOT_LO, ptr=0, memdata=0, boot_ready=0 during reset then 1, cpu_hold=1, boot_done=0, oob_err=0, low-byte holding register=0. RAM contents not cleared.
- boot_ready=1 in BOOT_LO/BOOT_HI, 0 in RUN. Byte accepted on boot_valid && boot_ready at a rising edge.
- BOOT_LO: accepted byte stored in holding register -> BOOT_HI.
- BOOT_HI: accepted byte forms word {boot_data, held_lo}, written to mem[ptr]; ptr+1; if ptr+1 == BOOT_LEN -> RUN else -> BOOT_LO.
- No accepted byte: state holds; gaps in boot_valid are legal.
- RUN: cpu_hold=0, boot_done=1; boot_valid ignored. Terminal until reset.
- During BOOT states: adr/memOut/strobes ignored, no CPU writes, memdata=0, oob_err unchanged.
- RUN reads: every cycle memdata <= mem[adr[ADDR_W-1:0]] if in range.
- RUN writes: memwrite_a writes byte 0, memwrite_b byte 1, both -> full word; untouched byte preserved.
- In range means adr[15:ADDR_W]==0. Out of range in RUN: writes dropped, memdata <= 0; oob_err set if any strobe is asserted or the read is out of range, sticky until reset.
- Read and write same address same cycle: memdata returns pre-write data (read-before-write).

## Timing

- Read latency 1 cycle: adr sampled at edge N, memdata valid after edge N, stable until edge N+1.
- Write committed at edge N; read of that address at edge N+1 returns new data.
- Boot: minimum 2*BOOT_LEN accepted bytes; cpu_hold deasserts and boot_done asserts after the edge accepting the final high byte.
- Reset mid-boot or mid-run: immediate return to BOOT_LO, ptr=0, cpu_hold=1; partially loaded words retain the values written so far.
- oob_err rises after the edge of the offending access.

## Test plan

- BOOT_LEN=4, stream bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with one-cycle gaps -> mem[0..3]=0x2211,0x4433,0x6655,0x8877; cpu_hold falls, boot_done rises after 8th accept; RUN reads of adr 0..3 return those values 1 cycle later.
- RUN, mem[5]=0xABCD, memOut=0x1234: memwrite_a only -> 0xAB34; then memwrite_b only -> 0x1234; both -> 0x1234.
- Same-cycle read/write adr=7, old 0x0F0F, memOut=0xBEEF both strobes -> memdata 0x0F0F, next cycle 0xBEEF.
- ADDR_W=8, adr=0x0100 with memwrite_a -> mem[0] unchanged, memdata=0, oob_err=1 and stays 1 for later in-range accesses.
- Reset deasserted/reasserted after 3 boot bytes -> state BOOT_LO, boot_ready=1, cpu_hold=1, memdata=0, oob_err=0; fresh 8-byte stream loads correctly.
- Strobes toggled during boot -> RAM contents unchanged by CPU side, memdata stays 0.
